// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates LSU/if0/if1 onto a byte-wide memory port, serialising
// accesses into per-byte bus cycles and reassembling read data.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  lsu_req,
  input  logic                  lsu_we,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic [2:0]            lsu_size,
  input  logic [WORD_WIDTH-1:0] lsu_wdata,
  output logic                  lsu_done,
  output logic [WORD_WIDTH-1:0] lsu_rdata,
  input  logic                  if0_req,
  input  logic [ADDR_WIDTH-1:0] if0_addr,
  output logic                  if0_done,
  output logic [WORD_WIDTH-1:0] if0_inst,
  input  logic                  if1_req,
  input  logic [ADDR_WIDTH-1:0] if1_addr,
  output logic                  if1_done,
  output logic [WORD_WIDTH-1:0] if1_inst,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_a
);
  localparam int NB = WORD_WIDTH / 8;
  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] base;
  logic [2:0] cnt, len, cap_lane;
  logic we, ptr, own_lsu, own_if0, own_if1;
  logic [WORD_WIDTH-1:0] wbuf, rbuf, rnext;
  logic e_lsu, e0, e1, merge, g0, g1, grant, last, cap;
  assign e_lsu = lsu_req & ~lsu_done;
  assign e0 = if0_req & ~if0_done;
  assign e1 = if1_req & ~if1_done;
  assign merge = e0 & e1 & (if0_addr == if1_addr);
  // ptr=0 favours if0; identical fetch addresses share one read
  assign g0 = ~e_lsu & e0 & (merge | ~e1 | ~ptr);
  assign g1 = ~e_lsu & e1 & (merge | ~e0 | ptr);
  assign grant = e_lsu | g0 | g1;
  assign last = cnt == len - 3'd1;
  // read bytes arrive one cycle after their address
  assign cap = (state == XFER && cnt != 3'd0 && !we) || state == DRAIN;
  assign cap_lane = state == DRAIN ? len - 3'd1 : cnt - 3'd1;
  always_comb begin
    rnext = rbuf;
    for (int b = 0; b < NB; b++)
      if (cap && cap_lane == 3'(b)) rnext[8*b +: 8] = mem_din;
  end
  always_comb begin
    state_n = state;
    mem_a = '0;
    mem_wr = 1'b0;
    mem_dout = '0;
    case (state)
      XFER: begin
        state_n = last ? (we ? IDLE : DRAIN) : XFER;
        mem_a = base + ADDR_WIDTH'(cnt);
        mem_wr = rdy & we;
        mem_dout = we ? wbuf[8*cnt +: 8] : '0;
      end
      DRAIN: state_n = IDLE;
      default: state_n = grant ? XFER : IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      base <= '0;
      cnt <= '0;
      len <= '0;
      we <= 1'b0;
      ptr <= 1'b0;
      own_lsu <= 1'b0;
      own_if0 <= 1'b0;
      own_if1 <= 1'b0;
      wbuf <= '0;
      rbuf <= '0;
      lsu_done <= 1'b0;
      if0_done <= 1'b0;
      if1_done <= 1'b0;
      lsu_rdata <= '0;
      if0_inst <= '0;
      if1_inst <= '0;
    end else if (rdy) begin
      state <= state_n;
      lsu_done <= 1'b0;
      if0_done <= 1'b0;
      if1_done <= 1'b0;
      if (state == IDLE && grant) begin
        base <= e_lsu ? lsu_addr : g0 ? if0_addr : if1_addr;
        len <= !e_lsu ? 3'(NB) : lsu_size == 3'd1 ? 3'd1 : lsu_size == 3'd2 ? 3'd2 : 3'(NB);
        we <= e_lsu & lsu_we;
        wbuf <= lsu_wdata;
        rbuf <= '0;
        cnt <= '0;
        own_lsu <= e_lsu;
        own_if0 <= g0;
        own_if1 <= g1;
        if (!e_lsu) ptr <= merge ? ~ptr : g0;
      end
      if (state == XFER) begin
        cnt <= cnt + 3'd1;
        rbuf <= rnext;
        if (last && we) lsu_done <= own_lsu;
      end
      if (state == DRAIN) begin
        lsu_done <= own_lsu;
        if0_done <= own_if0;
        if1_done <= own_if1;
        if (own_lsu) lsu_rdata <= rnext;
        if (own_if0) if0_inst <= rnext;
        if (own_if1) if1_inst <= rnext;
      end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter with a byte memory model.
module tb_mem_arbiter;
  logic clk = 0, rst = 1, rdy = 1;
  logic lsu_req = 0, lsu_we = 0, if0_req = 0, if1_req = 0;
  logic [31:0] lsu_addr = 0, lsu_wdata = 0, if0_addr = 0, if1_addr = 0;
  logic [2:0] lsu_size = 0;
  logic [7:0] mem_din = 0;
  logic lsu_done, if0_done, if1_done, mem_wr;
  logic [31:0] lsu_rdata, if0_inst, if1_inst, mem_a;
  logic [7:0] mem_dout;
  int cyc = 0, checks = 0, errors = 0, rd_count = 0, t;
  typedef struct {string tag; int who; logic [31:0] data; bit ck; int at;} exp_t;
  exp_t sb[$];
  logic [39:0] wr_log[$];

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_size(lsu_size),
    .lsu_wdata(lsu_wdata), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
    .if0_req(if0_req), .if0_addr(if0_addr), .if0_done(if0_done), .if0_inst(if0_inst),
    .if1_req(if1_req), .if1_addr(if1_addr), .if1_done(if1_done), .if1_inst(if1_inst),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_a(mem_a)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] byte_at(logic [31:0] a);
    case (a)
      32'h100: return 8'h13;
      32'h101: return 8'h05;
      32'h102: return 8'h10;
      32'h103: return 8'h00;
      default: return a[7:0] ^ a[15:8] ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [31:0] word_at(logic [31:0] a, int n);
    logic [31:0] w = 0;
    for (int k = 0; k < n; k++) w[8*k +: 8] = byte_at(a + 32'(k));
    return w;
  endfunction

  // memory shares the global enable, so a frozen read byte stays put
  always @(posedge clk) if (rdy) mem_din <= byte_at(mem_a);

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(string tag, int who, logic [31:0] data, bit ck, int at);
    sb.push_back('{tag, who, data, ck, at});
  endtask

  task automatic see(logic d, int who, logic [31:0] data);
    exp_t e;
    if (d !== 1'b1) return;
    if (sb.size() == 0) begin
      chk($sformatf("done%0d_unexpected_pending", who), 64'(sb.size()), 64'(1));
      return;
    end
    e = sb.pop_front();
    chk({e.tag, "_who"}, 64'(who), 64'(e.who));
    chk({e.tag, "_cycle"}, 64'(cyc), 64'(e.at));
    if (e.ck) chk({e.tag, "_data"}, 64'(data), 64'(e.data));
  endtask

  task automatic tick();
    @(negedge clk);
    if (mem_wr) wr_log.push_back({mem_a, mem_dout});
    if (mem_a != 0 && !mem_wr) rd_count++;
    see(lsu_done, 0, lsu_rdata);
    see(if0_done, 1, if0_inst);
    see(if1_done, 2, if1_inst);
    if (lsu_done) lsu_req = 0;
    if (if0_done) if0_req = 0;
    if (if1_done) if1_req = 0;
  endtask

  task automatic drain(int budget);
    for (int n = 0; n < budget && sb.size() != 0; n++) tick();
    chk("pending_after_budget", 64'(sb.size()), 64'(0));
    tick();
  endtask

  initial begin
    tick();
    chk("rst_bus", 64'({mem_wr, mem_a, mem_dout}), 64'(0));
    chk("rst_done", 64'({lsu_done, if0_done, if1_done}), 64'(0));
    chk("rst_data", {lsu_rdata, if0_inst}, 64'(0));
    chk("rst_if1", 64'(if1_inst), 64'(0));
    rst = 0;
    tick();
    // all three at once: LSU, then if0, then if1
    t = cyc + 1;
    lsu_req = 1; lsu_we = 0; lsu_size = 1; lsu_addr = 32'h301;
    if0_req = 1; if0_addr = 32'h200; if1_req = 1; if1_addr = 32'h280;
    push("pri_lsu", 0, word_at(32'h301, 1), 1, t + 2);
    push("pri_if0", 1, word_at(32'h200, 4), 1, t + 8);
    push("pri_if1", 2, word_at(32'h280, 4), 1, t + 14);
    drain(40);
    // plain fetch with bus trace
    t = cyc + 1;
    if0_req = 1; if0_addr = 32'h100;
    push("fetch", 1, 32'h00100513, 1, t + 5);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("fetch_a%0d", k), 64'(mem_a), 64'(32'h100 + k));
      chk($sformatf("fetch_wr%0d", k), 64'(mem_wr), 64'(0));
    end
    drain(20);
    // last fetch grant went to if0, so if1 wins next
    t = cyc + 1;
    if0_req = 1; if0_addr = 32'h200; if1_req = 1; if1_addr = 32'h280;
    push("rr_if1", 2, word_at(32'h280, 4), 1, t + 5);
    push("rr_if0", 1, word_at(32'h200, 4), 1, t + 11);
    drain(30);
    t = cyc + 1;
    rd_count = 0;
    if0_req = 1; if1_req = 1; if0_addr = 32'h40; if1_addr = 32'h40;
    push("merge_if0", 1, word_at(32'h40, 4), 1, t + 5);
    push("merge_if1", 2, word_at(32'h40, 4), 1, t + 5);
    drain(20);
    chk("merge_reads", 64'(rd_count), 64'(4));
    t = cyc + 1;
    wr_log.delete();
    lsu_req = 1; lsu_we = 1; lsu_size = 2; lsu_addr = 32'h2000; lsu_wdata = 32'hAABBCCDD;
    push("store", 0, 0, 0, t + 2);
    drain(10);
    lsu_we = 0;
    chk("store_count", 64'(wr_log.size()), 64'(2));
    chk("store_w0", 64'(wr_log[0]), 64'({32'h2000, 8'hDD}));
    chk("store_w1", 64'(wr_log[1]), 64'({32'h2001, 8'hCC}));
    // freeze three cycles while byte 1 is on the bus
    t = cyc + 1;
    lsu_req = 1; lsu_size = 4; lsu_addr = 32'h500;
    push("stall", 0, word_at(32'h500, 4), 1, t + 8);
    tick();
    tick();
    rdy = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stall_a%0d", k), 64'(mem_a), 64'(32'h501));
      chk($sformatf("stall_wr%0d", k), 64'(mem_wr), 64'(0));
    end
    rdy = 1;
    drain(20);
    t = cyc + 1;
    if0_req = 1; if0_addr = 32'h600;
    push("pre_rst_fetch", 1, word_at(32'h600, 4), 1, t + 5);
    drain(20);
    // abort a store mid-transfer
    wr_log.delete();
    lsu_req = 1; lsu_we = 1; lsu_size = 4; lsu_addr = 32'h3000; lsu_wdata = 32'h11223344;
    tick();
    tick();
    #2 rst = 1;
    lsu_req = 0;
    #1;
    chk("async_rst_bus", 64'({mem_wr, mem_a, mem_dout}), 64'(0));
    chk("async_rst_inst", 64'(if0_inst), 64'(0));
    tick();
    rst = 0;
    repeat (6) tick();
    chk("abort_writes", 64'(wr_log.size()), 64'(2));
    wr_log.delete();
    t = cyc + 1;
    lsu_req = 1;
    push("restore", 0, 0, 0, t + 4);
    drain(10);
    lsu_we = 0;
    chk("restore_count", 64'(wr_log.size()), 64'(4));
    chk("restore_w3", 64'(wr_log[3]), 64'({32'h3003, 8'h11}));
    // reset returns the round-robin pointer to if0
    t = cyc + 1;
    if0_req = 1; if0_addr = 32'h700; if1_req = 1; if1_addr = 32'h780;
    push("post_rst_if0", 1, word_at(32'h700, 4), 1, t + 5);
    push("post_rst_if1", 2, word_at(32'h780, 4), 1, t + 11);
    drain(30);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single byte-wide RAM/IO port between three requesters: the load/store unit (LSU) and two instruction-fetch ports (if0, if1).
- Arbitrates, serialises each word/half/byte access into per-byte bus cycles, reassembles read data and pulses a per-requester done.
- Sits between the instruction cache / LSU and the top-level memory pins.

Parameters:
- ADDR_WIDTH, 32, width of all address ports.
- WORD_WIDTH, 32, width of data words.

Ports:
- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- rdy  in  1  global enable; low = freeze
- lsu_req  in  1  LSU access request, level, held until lsu_done
- lsu_we  in  1  1=store, 0=load
- lsu_addr  in  32  byte address
- lsu_size  in  3  bytes to transfer: 1, 2, else treated as 4
- lsu_wdata  in  32  store data, byte 0 in bits 7:0
- lsu_done  out  1  one-cycle completion pulse
- lsu_rdata  out  32  load data, little-endian, zero-extended above size
- if0_req  in  1  fetch request, level, held until if0_done
- if0_addr  in  32  fetch address (4-byte read)
- if0_done  out  1  one-cycle completion pulse
- if0_inst  out  32  fetched word
- if1_req, if1_addr, if1_done, if1_inst: same as if0
- mem_din  in  8  byte from memory, valid the cycle after its address
- mem_dout  out  8  byte to memory
- mem_wr  out  1  1=write, 0=read
- mem_a  out  32  memory byte address

Behaviour:
- Reset (asynchronous, any state, including mid-transfer): state IDLE; all done=0; lsu_rdata, if0_inst, if1_inst, mem_dout, mem_a = 0; mem_wr=0; round-robin pointer favours if0. An aborted transfer never signals done.
- rdy=0: no register updates; outputs hold, except mem_wr is forced 0. mem_a is held, so a pending read byte is re-read unchanged.
- States: IDLE, XFER (issue bytes), DRAIN (capture last read byte).
- IDLE, at a rising edge:
  - Eligible requesters are those with req=1 and their own done currently 0.
  - LSU has strict priority over if0/if1.
  - Between if0 and if1: round-robin. The pointer flips to the other port after each fetch grant.
  - If if0 and if1 are both eligible with equal addresses, one read is performed and both done pulse together.
  - Grant latches address, size, we and wdata; sets byte counter i=0; enters XFER.
- XFER, cycle k (k=0..N-1): mem_a=base+k.
  - Store: mem_wr=1, mem_dout=wdata byte k.
  - Load/fetch: mem_wr=0, mem_dout=0.
  - The read byte for address k is sampled at the end of cycle k+1 into byte lane k.
- After byte N-1 is issued:
  - Store: done asserts on that same edge; return to IDLE.
  - Read: enter DRAIN for one cycle (mem_a=0, mem_wr=0), capture the last byte, assert done and data on that edge; return to IDLE.
- Latency, with req sampled at edge t in IDLE:
  - Read of N bytes: done/data valid after edge t+N+1 (N=4 gives t+5).
  - Store of N bytes: done after edge t+N.
- done is high exactly one cycle. The requester must drop req in that cycle; a req seen while its own done is high is ignored.
- IDLE bus outputs: mem_wr=0, mem_a=0, mem_dout=0.
- Data outputs hold their last value between transfers and are only valid with done.
- Address arithmetic is ADDR_WIDTH wrap-around (0xFFFFFFFF+1 = 0).
- Back-to-back: a new grant may occur on the first edge in IDLE, i.e. the edge after done is raised.

Test Plan:
- Fetch: if0_req, if0_addr=0x100, memory bytes 0x13,0x05,0x10,0x00 at 0x100..0x103 -> mem_a 0x100..0x103 on consecutive cycles; if0_done after edge t+5; if0_inst=0x00100513.
- Store: lsu_we=1, size=2, addr=0x2000, wdata=0xAABBCCDD -> two write cycles: (0x2000,0xDD), (0x2001,0xCC); lsu_done after edge t+2; 0xBB never written.
- Priority/round-robin: lsu, if0, if1 all raised together -> order LSU, if0, if1. Repeat with if0 and if1 only -> if1 is served before if0 (pointer flipped after the last fetch grant, which was to if0).
- Merge: if0_addr=if1_addr=0x40, both raised -> exactly 4 read cycles; if0_done and if1_done in the same cycle with equal data.
- Stall: drop rdy for 3 cycles mid-load (size 4) -> mem_wr stays 0, mem_a held; done is delayed by exactly 3 cycles; data is correct.
- Reset: assert rst during XFER of a store -> outputs immediately 0 (asynchronous); no lsu_done; after release, a re-issued request completes normally.
